shift_left: RTL and testbench

SHIFT_LEFT -- requirements
Module: shift_left

---
 rtl/shift_left_pkg.sv | 7 +
 rtl/shift_left_core.sv | 40 ++++
 rtl/shift_left.sv | 62 ++++++
 tb/tb_shift_left.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/shift_left_pkg.sv
// Shared constants for the registered logarithmic left shifter.
package shift_left_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 20;
  localparam int unsigned DEF_SHIFT_WIDTH = 5;

endpackage : shift_left_pkg

// File: rtl/shift_left_core.sv
// Combinational barrel shifter: next shifted value plus a sticky flag for
// any 1 bit pushed past the MSB.
module shift_left_core
  import shift_left_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHIFT_WIDTH-1:0] amount_i,
  output logic [DATA_WIDTH-1:0]  data_c,
  output logic                   overflow_c
);

  logic [DATA_WIDTH-1:0] stage_val [SHIFT_WIDTH+1];
  logic                  stage_ovf [SHIFT_WIDTH+1];

  assign stage_val[0] = data_i;
  assign stage_ovf[0] = 1'b0;

  // Stage k shifts by 2^k; bits leaving the top accumulate into the overflow chain.
  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam longint unsigned STEP = 64'(1) << k;
    if (STEP >= 64'(DATA_WIDTH)) begin : g_full
      assign stage_val[k+1] = amount_i[k] ? '0 : stage_val[k];
      assign stage_ovf[k+1] = stage_ovf[k] | (amount_i[k] & (|stage_val[k]));
    end else begin : g_part
      localparam int unsigned S = 32'(STEP);
      assign stage_val[k+1] = amount_i[k]
                            ? {stage_val[k][DATA_WIDTH-1-S:0], {S{1'b0}}}
                            : stage_val[k];
      assign stage_ovf[k+1] = stage_ovf[k]
                            | (amount_i[k] & (|stage_val[k][DATA_WIDTH-1 -: S]));
    end
  end

  assign data_c     = stage_val[SHIFT_WIDTH];
  assign overflow_c = stage_ovf[SHIFT_WIDTH];

endmodule : shift_left_core

// File: rtl/shift_left.sv
// Registered left shifter: one-cycle latency, one operand per cycle, no backpressure.
module shift_left
  import shift_left_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_amount,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   overflow
);

  logic [DATA_WIDTH-1:0] shifted_c;
  logic                  ovf_c;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;

  shift_left_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_core (
    .data_i     (data_in),
    .amount_i   (shift_amount),
    .data_c     (shifted_c),
    .overflow_c (ovf_c)
  );

  // Result registers load only on a valid operand; otherwise they hold.
  always_comb begin
    out_valid_d = in_valid;
    data_d      = data_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      data_d = shifted_c;
      ovf_d  = ovf_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign overflow  = ovf_q;

endmodule : shift_left

// File: tb/tb_shift_left.sv
// Directed self-checking bench for shift_left with hand-computed expectations.
module tb_shift_left;

  localparam int unsigned DW = 20;
  localparam int unsigned SW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] data_in;
  logic [SW-1:0] shift_amount;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  shift_left #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .out_valid    (out_valid),
    .data_out     (data_out),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] a);
    in_valid     = v;
    data_in      = d;
    shift_amount = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 20'hFFFFF, 5'd1);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++;
    if (data_out !== 20'h0) begin n_bad++; $display("FAIL reset_data got %h want 00000", data_out); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    drive(1'b0, '0, '0);
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic check_result(input string name, input logic [DW-1:0] d, input logic [SW-1:0] a,
                              input logic [DW-1:0] exp_d, input logic exp_o);
    drive(1'b1, d, a);
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || data_out !== exp_d || overflow !== exp_o) begin
      n_bad++;
      $display("FAIL %s got v=%b d=%h o=%b want v=1 d=%h o=%b",
               name, out_valid, data_out, overflow, exp_d, exp_o);
    end
  endtask

  task automatic test_shift();
    check_result("shift3", 20'hAAAAA, 5'd3, 20'h55550, 1'b1);
    check_result("shift7", 20'h8A8AA, 5'd7, 20'h45500, 1'b1);
    check_result("zero_shift", 20'h00F0F, 5'd0, 20'h00F0F, 1'b0);
    check_result("clean_shift4", 20'h00F0F, 5'd4, 20'h0F0F0, 1'b0);
    check_result("shift19_lsb", 20'h00001, 5'd19, 20'h80000, 1'b0);
    check_result("shift1_msb", 20'h80000, 5'd1, 20'h00000, 1'b1);
    check_result("shift16", 20'h1234F, 5'd16, 20'hF0000, 1'b1);
  endtask

  task automatic test_oversize();
    check_result("over20_one", 20'h00001, 5'd20, 20'h00000, 1'b1);
    check_result("over31_zero", 20'h00000, 5'd31, 20'h00000, 1'b0);
    check_result("over25_msb", 20'h80000, 5'd25, 20'h00000, 1'b1);
  endtask

  task automatic test_hold();
    check_result("hold_load", 20'h00F0F, 5'd2, 20'h03C3C, 1'b0);
    drive(1'b0, 20'hFFFFF, 5'd9);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || data_out !== 20'h03C3C || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL hold got v=%b d=%h o=%b want v=0 d=03c3c o=0", out_valid, data_out, overflow);
    end
  endtask

  task automatic test_back_to_back();
    check_result("b2b_0", 20'h00003, 5'd1, 20'h00006, 1'b0);
    check_result("b2b_1", 20'hC0000, 5'd1, 20'h80000, 1'b1);
    check_result("b2b_2", 20'h00005, 5'd8, 20'h00500, 1'b0);
  endtask

  task automatic test_midstream_reset();
    check_result("pre_reset", 20'h00011, 5'd4, 20'h00110, 1'b0);
    drive(1'b1, 20'hFFFFF, 5'd2);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || data_out !== 20'h0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL async_clear got v=%b d=%h o=%b want v=0 d=00000 o=0", out_valid, data_out, overflow);
    end
    tick();
    drive(1'b0, '0, '0);
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || data_out !== 20'h0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL discarded got v=%b d=%h o=%b want v=0 d=00000 o=0", out_valid, data_out, overflow);
    end
    check_result("first_after_reset", 20'h00101, 5'd3, 20'h00808, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, '0);
    rst_n = 1'b0;
    test_reset();
    test_shift();
    test_oversize();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_left
